// File: rtl/code_decoder_seq_if.sv
// code_decoder_seq_if: handshake and output bundle for the sequenced 2-to-4 decoder.
//   in_valid  - source presents in_code this cycle
//   in_code   - 2-bit code to decode (0 selects Y[0] .. 3 selects Y[3])
//   in_ready  - decoder FIFO can accept a code (not full)
//   Y         - one-hot decoded word, 0000 when idle
//   out_valid - high exactly when Y is non-zero
//   count     - FIFO occupancy, 0..DEPTH
// The master modport is the code source; the slave modport is the decoder.
interface code_decoder_seq_if #(
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          in_valid;
  logic [1:0]    in_code;
  logic          in_ready;
  logic [3:0]    Y;
  logic          out_valid;
  logic [CW-1:0] count;

  modport master (
    output in_valid, in_code,
    input  in_ready, Y, out_valid, count
  );

  modport slave (
    input  in_valid, in_code,
    output in_ready, Y, out_valid, count
  );
endinterface

// File: rtl/code_decoder_seq.sv
// code_decoder_seq: sequenced 2-to-4 decoder.
// Codes arrive over a valid/ready handshake, are buffered in a DEPTH-entry
// FIFO, and are replayed one at a time as a one-hot word on Y, each held for
// DWELL cycles. Consecutive words follow each other without a gap cycle.
//   clk - rising-edge clock
//   rst - synchronous active-high reset
//   bus - code_decoder_seq_if slave modport (in_valid, in_code, in_ready,
//         Y, out_valid, count)
// Parameters: DEPTH (power of 2, >= 2), DWELL (>= 1).
module code_decoder_seq #(
  parameter int DEPTH = 4,
  parameter int DWELL = 3
) (
  input  logic                clk,
  input  logic                rst,
  code_decoder_seq_if.slave   bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int DW = (DWELL > 1) ? $clog2(DWELL) : 1;

  typedef enum logic {
    IDLE,
    DRIVE
  } state_t;

  state_t        state_q, state_d;
  logic [1:0]    mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count_q;
  logic [DW-1:0] dwell_q, dwell_d;
  logic [3:0]    y_q, y_d;
  logic          ov_q, ov_d;
  logic          in_ready_w;
  logic          push, pop;
  logic [3:0]    head_word;

  // Readiness comes from the pre-edge count, so a pop on the same edge
  // never frees a slot for a push.
  assign in_ready_w = (count_q != CW'(DEPTH));
  assign push       = bus.in_valid && in_ready_w;
  assign head_word  = 4'b0001 << mem[rd_ptr];

  assign bus.in_ready  = in_ready_w;
  assign bus.Y         = y_q;
  assign bus.out_valid = ov_q;
  assign bus.count     = count_q;

  // FIFO storage and pointers. Pointers are PW bits wide, so with a
  // power-of-2 DEPTH they wrap naturally. Storage itself needs no reset:
  // clearing count and pointers makes old contents unreachable.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= bus.in_code;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      count_q <= count_q + CW'(push) - CW'(pop);
    end
  end

  // FSM and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      dwell_q <= '0;
      y_q     <= '0;
      ov_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      dwell_q <= dwell_d;
      y_q     <= y_d;
      ov_q    <= ov_d;
    end
  end

  // Next-state logic. A word is loaded whenever the current one has
  // finished (or none is showing) and the FIFO holds a code; the dwell
  // counter holds the number of extra cycles the current word remains.
  always_comb begin
    state_d = state_q;
    dwell_d = dwell_q;
    y_d     = y_q;
    ov_d    = ov_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        y_d  = 4'b0000;
        ov_d = 1'b0;
        if (count_q != '0) begin
          pop     = 1'b1;
          y_d     = head_word;
          ov_d    = 1'b1;
          dwell_d = DW'(DWELL - 1);
          state_d = DRIVE;
        end
      end
      DRIVE: begin
        if (dwell_q != '0) begin
          dwell_d = dwell_q - DW'(1);
        end else if (count_q != '0) begin
          pop     = 1'b1;
          y_d     = head_word;
          ov_d    = 1'b1;
          dwell_d = DW'(DWELL - 1);
        end else begin
          y_d     = 4'b0000;
          ov_d    = 1'b0;
          state_d = IDLE;
        end
      end
      default: begin
        y_d     = 4'b0000;
        ov_d    = 1'b0;
        dwell_d = '0;
        state_d = IDLE;
      end
    endcase
  end
endmodule

// File: tb/tb_code_decoder_seq.sv
// tb_code_decoder_seq: self-checking bench for code_decoder_seq.
// Two decoders share one stimulus stream: one with DWELL=3, one with DWELL=1,
// both DEPTH=4. A reference model kept as a code queue plus "word currently
// shown and cycles it has left" predicts Y, out_valid, count and in_ready
// after every edge. Directed steps follow the lab test plan, then a random
// phase mixes pushes, idles and occasional resets.
module tb_code_decoder_seq;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  code_decoder_seq_if #(.DEPTH(DEPTH)) bus3 ();
  code_decoder_seq_if #(.DEPTH(DEPTH)) bus1 ();

  code_decoder_seq #(.DEPTH(DEPTH), .DWELL(3)) dut3 (
    .clk (clk),
    .rst (rst),
    .bus (bus3.slave)
  );

  code_decoder_seq #(.DEPTH(DEPTH), .DWELL(1)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1.slave)
  );

  // Reference model: index 0 is the DWELL=3 decoder, index 1 the DWELL=1 one.
  int dwell_of [2] = '{3, 1};
  int mq [2][$];
  int cur [2];
  int rem [2];

  int compared   = 0;
  int mismatched = 0;

  task automatic cmp(input string tag, input int inst, input logic [7:0] obs, input logic [7:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s dwell=%0d observed=%0h expected=%0h", tag, dwell_of[inst], obs, exp);
    end
  endtask

  task automatic modelReset();
    for (int i = 0; i < 2; i++) begin
      mq[i].delete();
      cur[i] = -1;
      rem[i] = 0;
    end
  endtask

  // Compare every output of both decoders against the model.
  task automatic checkOutput();
    for (int i = 0; i < 2; i++) begin
      logic [3:0] exp_y;
      logic [3:0] obs_y;
      logic       obs_ov;
      logic       obs_rdy;
      logic [7:0] obs_cnt;
      exp_y = (cur[i] < 0) ? 4'b0000 : 4'(1 << cur[i]);
      if (i == 0) begin
        obs_y = bus3.Y; obs_ov = bus3.out_valid; obs_rdy = bus3.in_ready; obs_cnt = 8'(bus3.count);
      end else begin
        obs_y = bus1.Y; obs_ov = bus1.out_valid; obs_rdy = bus1.in_ready; obs_cnt = 8'(bus1.count);
      end
      cmp("Y", i, 8'(obs_y), 8'(exp_y));
      cmp("out_valid", i, 8'(obs_ov), 8'(cur[i] >= 0));
      cmp("count", i, obs_cnt, 8'(mq[i].size()));
      cmp("in_ready", i, 8'(obs_rdy), 8'(mq[i].size() != DEPTH));
    end
  endtask

  // Drive one cycle of inputs, advance the model across the edge, check.
  // acc3 reports whether the DWELL=3 decoder accepts the code on this edge.
  task automatic applyStimulus(input bit r, input bit v, input logic [1:0] code, output bit acc3);
    bit rdy [2];
    rst = r;
    bus3.in_valid = v; bus3.in_code = code;
    bus1.in_valid = v; bus1.in_code = code;
    for (int i = 0; i < 2; i++) rdy[i] = (mq[i].size() != DEPTH);
    acc3 = !r && v && rdy[0];
    @(posedge clk);
    if (r) begin
      modelReset();
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (cur[i] < 0 || rem[i] == 1) begin
          if (mq[i].size() > 0) begin
            cur[i] = mq[i].pop_front();
            rem[i] = dwell_of[i];
          end else begin
            cur[i] = -1;
            rem[i] = 0;
          end
        end else begin
          rem[i]--;
        end
        if (v && rdy[i]) mq[i].push_back(int'(code));
      end
    end
    #1;
    checkOutput();
  endtask

  initial begin
    bit acc;
    bit saw_full;
    bit found;
    int idx;
    logic [1:0] seq4 [8] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3};

    modelReset();
    rst = 1'b1;
    bus3.in_valid = 1'b0; bus3.in_code = 2'b00;
    bus1.in_valid = 1'b0; bus1.in_code = 2'b00;

    // Reset for two edges, then idle.
    applyStimulus(1, 0, 2'd0, acc);
    applyStimulus(1, 0, 2'd0, acc);
    for (int k = 0; k < 3; k++) applyStimulus(0, 0, 2'd0, acc);
    cmp("t1_idle_y", 0, 8'(bus3.Y), 8'h00);
    cmp("t1_ready", 0, 8'(bus3.in_ready), 8'h01);

    // Single code 2'b10.
    applyStimulus(0, 1, 2'd2, acc);
    applyStimulus(0, 0, 2'd0, acc);
    cmp("t2_y_first", 0, 8'(bus3.Y), 8'h04);
    applyStimulus(0, 0, 2'd0, acc);
    applyStimulus(0, 0, 2'd0, acc);
    cmp("t2_y_last", 0, 8'(bus3.Y), 8'h04);
    applyStimulus(0, 0, 2'd0, acc);
    cmp("t2_y_done", 0, 8'(bus3.Y), 8'h00);

    // Back-to-back 00,01,10,11.
    for (int k = 0; k < 4; k++) applyStimulus(0, 1, 2'(k), acc);
    for (int k = 0; k < 9; k++) applyStimulus(0, 0, 2'd0, acc);
    cmp("t3_y_last_word", 0, 8'(bus3.Y), 8'h08);
    applyStimulus(0, 0, 2'd0, acc);
    cmp("t3_y_done", 0, 8'(bus3.Y), 8'h00);

    // Full / backpressure with pointer wrap; source holds code until taken.
    idx = 0;
    saw_full = 1'b0;
    for (int k = 0; k < 40 && idx < 8; k++) begin
      applyStimulus(0, 1, seq4[idx], acc);
      if (acc) idx++;
      if (bus3.count == 3'd4 && !bus3.in_ready) saw_full = 1'b1;
    end
    cmp("t4_all_accepted", 0, 8'(idx), 8'd8);
    cmp("t4_saw_full", 0, 8'(saw_full), 8'h01);
    for (int k = 0; k < 30; k++) applyStimulus(0, 0, 2'd0, acc);

    // Reset mid-drive.
    for (int k = 0; k < 4; k++) applyStimulus(0, 1, 2'(k), acc);
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      applyStimulus(0, 0, 2'd0, acc);
      if (bus3.Y === 4'b0010) found = 1'b1;
    end
    cmp("t5_reached_0010", 0, 8'(found), 8'h01);
    cmp("t5_count_before", 0, 8'(bus3.count), 8'd2);
    applyStimulus(1, 0, 2'd0, acc);
    cmp("t5_y_after_rst", 0, 8'(bus3.Y), 8'h00);
    applyStimulus(0, 1, 2'd3, acc);
    applyStimulus(0, 0, 2'd0, acc);
    cmp("t5_y_1000", 0, 8'(bus3.Y), 8'h08);
    for (int k = 0; k < 4; k++) applyStimulus(0, 0, 2'd0, acc);

    // DWELL=1 sequence 11,00,01 after a clean reset.
    applyStimulus(1, 0, 2'd0, acc);
    applyStimulus(0, 1, 2'd3, acc);
    applyStimulus(0, 1, 2'd0, acc);
    cmp("t6_y_1000", 1, 8'(bus1.Y), 8'h08);
    applyStimulus(0, 1, 2'd1, acc);
    cmp("t6_y_0001", 1, 8'(bus1.Y), 8'h01);
    applyStimulus(0, 0, 2'd0, acc);
    cmp("t6_y_0010", 1, 8'(bus1.Y), 8'h02);
    applyStimulus(0, 0, 2'd0, acc);
    cmp("t6_y_idle", 1, 8'(bus1.Y), 8'h00);
    for (int k = 0; k < 10; k++) applyStimulus(0, 0, 2'd0, acc);

    // Random traffic with occasional resets.
    for (int k = 0; k < 600; k++) begin
      applyStimulus($urandom_range(0, 63) == 0, $urandom_range(0, 2) != 0,
                    2'($urandom_range(0, 3)), acc);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
